// File: rtl/reg_mux_stage.sv
// ============================================================================
// Module      : reg_mux_stage
// Description : Single-stage operand register with parameter-selected bypass
//               for the DSP48A1 slice datapath. Optional macro
//               REG_MUX_BYPASS_RST_EN forces the bypass output to zero during
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_mux_stage #(
    parameter int Xy_REG = 0,
    parameter int WIDTH  = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_q;

    // The stage register exists in both modes so every instance has the same
    // clocked footprint; only the output selection differs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clk_en) begin
            r_q <= d;
        end
    end

    generate
        if (Xy_REG == 1) begin : g_registered
            assign out = r_q;
        end else begin : g_bypass
            // Register contents are intentionally discarded in bypass mode.
            logic w_unused_q;
            assign w_unused_q = ^r_q;
`ifdef REG_MUX_BYPASS_RST_EN
            assign out = rst ? '0 : d;
`else
            assign out = d;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_mux_stage.sv
// ============================================================================
// Module      : tb_reg_mux_stage
// Description : Directed self-checking bench for reg_mux_stage, covering a
//               registered and a bypass instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_mux_stage;

    localparam int c_WIDTH = 18;

    logic               clk;
    logic               rst;
    logic               clk_en;
    logic [c_WIDTH-1:0] d;
    logic [c_WIDTH-1:0] w_out_reg;
    logic [c_WIDTH-1:0] w_out_byp;

    int n_checks;
    int n_fail;

    reg_mux_stage #(
        .Xy_REG (1),
        .WIDTH  (c_WIDTH)
    ) u_dut_reg (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .d      (d),
        .out    (w_out_reg)
    );

    reg_mux_stage #(
        .Xy_REG (0),
        .WIDTH  (c_WIDTH)
    ) u_dut_byp (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .d      (d),
        .out    (w_out_byp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [c_WIDTH-1:0] obs,
                         input logic [c_WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bypass output while rst is high.
    function automatic logic [c_WIDTH-1:0] byp_rst_exp(input logic [c_WIDTH-1:0] din);
`ifdef REG_MUX_BYPASS_RST_EN
        return '0;
`else
        return din;
`endif
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with clk_en low
        rst    = 1'b1;
        clk_en = 1'b0;
        d      = 18'h12345;
        @(negedge clk);
        check("reg_reset", w_out_reg, 18'h00000);
        check("byp_during_reset", w_out_byp, byp_rst_exp(18'h12345));

        // Hold: clk_en low, d changes must not propagate
        rst    = 1'b0;
        clk_en = 1'b0;
        d      = 18'h3ABCD;
        #1;
        check("byp_after_reset", w_out_byp, 18'h3ABCD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reg_hold", w_out_reg, 18'h00000);
        end

        // Capture first value
        clk_en = 1'b1;
        d      = 18'h00F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reg_capture_0f0f", w_out_reg, 18'h00F0F);
        end

        // Capture second value
        d = 18'h2AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reg_capture_2aaaa", w_out_reg, 18'h2AAAA);
        end

        // Reset wins over clk_en
        rst    = 1'b1;
        clk_en = 1'b1;
        d      = 18'h15555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reg_reset_priority", w_out_reg, 18'h00000);
        end

        // First capture on the first edge with rst low
        rst = 1'b0;
        @(negedge clk);
        check("reg_capture_after_rst", w_out_reg, 18'h15555);

        // Hold the captured value with clk_en low
        clk_en = 1'b0;
        d      = 18'h00000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reg_hold_nonzero", w_out_reg, 18'h15555);
        end

        // Bypass: combinational response without clock edges
        d   = 18'h1F00F;
        rst = 1'b1;
        #1;
        check("byp_rst_1f00f", w_out_byp, byp_rst_exp(18'h1F00F));
        rst = 1'b0;
        #1;
        check("byp_rst_drop_1f00f", w_out_byp, 18'h1F00F);
        rst    = 1'b1;
        clk_en = 1'b0;
        d      = 18'h00123;
        #1;
        check("byp_rst_00123", w_out_byp, byp_rst_exp(18'h00123));
        rst = 1'b0;
        #1;
        check("byp_00123", w_out_byp, 18'h00123);
        d = 18'h3FFFF;
        #1;
        check("byp_all_ones", w_out_byp, 18'h3FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
